// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the game-flow controller: layer indices, state
// encodings, default timeouts and the per-state overlay mask.
package game_ctrl_pkg;

    localparam int LAYER_BG     = 0;
    localparam int LAYER_START  = 1;
    localparam int LAYER_BLOCKS = 2;
    localparam int LAYER_TIME   = 3;
    localparam int LAYER_CHAR   = 4;
    localparam int LAYER_POINTS = 5;
    localparam int LAYER_END    = 6;
    localparam int N_CORE_LAYERS = 7;

    localparam int DEF_JUMP_TIMEOUT_MS = 2000;
    localparam int DEF_END_LOCKOUT_MS  = 1000;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_END   = 2'd2
    } state_t;

    // Overlay enables for a given state; anything unknown shows the start screen.
    function automatic logic [N_CORE_LAYERS-1:0] layer_mask(state_t s);
        logic [N_CORE_LAYERS-1:0] m;
        m = '0;
        m[LAYER_BG] = 1'b1;
        case (s)
            ST_PLAY: begin
                m[LAYER_BLOCKS] = 1'b1;
                m[LAYER_TIME]   = 1'b1;
                m[LAYER_CHAR]   = 1'b1;
                m[LAYER_POINTS] = 1'b1;
            end
            ST_END: begin
                m[LAYER_BLOCKS] = 1'b1;
                m[LAYER_POINTS] = 1'b1;
                m[LAYER_END]    = 1'b1;
            end
            default: m[LAYER_START] = 1'b1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/game_ctrl_countdown.sv
// Millisecond countdown shared by the jump timeout and the end-screen lockout.
module ms_countdown #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             one_ms_tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire,
    output logic             is_zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (one_ms_tick && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // Fires on the tick that takes the count from 1 to 0, so the owner can
    // react on the same edge the counter empties.
    assign expire  = one_ms_tick && (cnt == CNT_W'(1));
    assign is_zero = (cnt == '0);

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: start screen -> play -> end screen, jump gating,
// time-bar restarts, score and best score.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int N_LAYERS        = 7,
    parameter int JUMP_TIMEOUT_MS = DEF_JUMP_TIMEOUT_MS,
    parameter int END_LOCKOUT_MS  = DEF_END_LOCKOUT_MS,
    parameter int POINTS_W        = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                one_ms_tick,
    input  logic                btn_start,
    input  logic                jump_left,
    input  logic                jump_right,
    input  logic                landed_ok,
    input  logic                landed_miss,
    output logic [N_LAYERS-1:0] layer_en,
    output logic                jump_left_out,
    output logic                jump_right_out,
    output logic                time_bar_start,
    output logic [POINTS_W-1:0] points,
    output logic [POINTS_W-1:0] best_points,
    output logic                game_over,
    output logic [1:0]          state_out
);

    localparam int CD_MAX = (JUMP_TIMEOUT_MS > END_LOCKOUT_MS) ? JUMP_TIMEOUT_MS : END_LOCKOUT_MS;
    localparam int CD_W   = $clog2(CD_MAX + 1);
    localparam logic [POINTS_W-1:0] PTS_MAX = '1;

    state_t              state, state_nxt;
    logic [POINTS_W-1:0] points_nxt, best_nxt;
    logic                jl_nxt, jr_nxt, tb_nxt;
    logic                cd_load, cd_expire, cd_zero;
    logic [CD_W-1:0]     cd_val;
    logic [N_CORE_LAYERS-1:0] mask_nxt;
    logic [N_LAYERS-1:0] lay_nxt;
    logic                one_jump;

    assign one_jump = jump_left ^ jump_right;

    ms_countdown #(.CNT_W(CD_W)) u_cd (
        .clk         (clk),
        .rst         (rst),
        .one_ms_tick (one_ms_tick),
        .load        (cd_load),
        .load_val    (cd_val),
        .expire      (cd_expire),
        .is_zero     (cd_zero)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_START;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        points_nxt = points;
        best_nxt   = best_points;
        jl_nxt     = 1'b0;
        jr_nxt     = 1'b0;
        tb_nxt     = 1'b0;
        cd_load    = 1'b0;
        cd_val     = '0;
        case (state)
            ST_START: begin
                if (btn_start || jump_left || jump_right) begin
                    state_nxt  = ST_PLAY;
                    points_nxt = '0;
                    cd_load    = 1'b1;
                    cd_val     = CD_W'(JUMP_TIMEOUT_MS);
                    tb_nxt     = 1'b1;
                end
            end
            ST_PLAY: begin
                // Miss or timeout end the round and suppress any score or jump.
                if (landed_miss || cd_expire) begin
                    state_nxt = ST_END;
                    best_nxt  = (points > best_points) ? points : best_points;
                    cd_load   = 1'b1;
                    cd_val    = CD_W'(END_LOCKOUT_MS);
                end else begin
                    if (landed_ok && points != PTS_MAX)
                        points_nxt = points + 1'b1;
                    if (one_jump) begin
                        jl_nxt  = jump_left;
                        jr_nxt  = jump_right;
                        tb_nxt  = 1'b1;
                        cd_load = 1'b1;
                        cd_val  = CD_W'(JUMP_TIMEOUT_MS);
                    end
                end
            end
            ST_END: begin
                if (cd_zero && btn_start)
                    state_nxt = ST_START;
            end
            default: state_nxt = ST_START;
        endcase
    end

    assign mask_nxt = layer_mask(state_nxt);

    for (genvar g = 0; g < N_LAYERS; g++) begin : g_lay
        if (g < N_CORE_LAYERS) begin : g_core
            assign lay_nxt[g] = mask_nxt[g];
        end else begin : g_spare
            assign lay_nxt[g] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            layer_en       <= N_LAYERS'(2'b11);
            jump_left_out  <= 1'b0;
            jump_right_out <= 1'b0;
            time_bar_start <= 1'b0;
            points         <= '0;
            best_points    <= '0;
            game_over      <= 1'b0;
        end else begin
            layer_en       <= lay_nxt;
            jump_left_out  <= jl_nxt;
            jump_right_out <= jr_nxt;
            time_bar_start <= tb_nxt;
            points         <= points_nxt;
            best_points    <= best_nxt;
            game_over      <= (state_nxt == ST_END);
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl with short timeouts and a 3-bit score.
module tb_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       one_ms_tick = 1'b0, btn_start = 1'b0, jump_left = 1'b0, jump_right = 1'b0;
    logic       landed_ok = 1'b0, landed_miss = 1'b0;
    logic [6:0] layer_en;
    logic       jump_left_out, jump_right_out, time_bar_start, game_over;
    logic [2:0] points, best_points;
    logic [1:0] state_out;

    game_ctrl #(
        .N_LAYERS(7), .JUMP_TIMEOUT_MS(5), .END_LOCKOUT_MS(3), .POINTS_W(3)
    ) dut (
        .clk(clk), .rst(rst), .one_ms_tick(one_ms_tick), .btn_start(btn_start),
        .jump_left(jump_left), .jump_right(jump_right), .landed_ok(landed_ok),
        .landed_miss(landed_miss), .layer_en(layer_en), .jump_left_out(jump_left_out),
        .jump_right_out(jump_right_out), .time_bar_start(time_bar_start),
        .points(points), .best_points(best_points), .game_over(game_over),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [6:0] lay;
        logic       jl, jr, tb;
        logic [2:0] pts, best;
        logic       go;
    } obs_t;

    typedef struct {
        int    due;
        obs_t  e;
        string nm;
    } sb_t;

    localparam logic [1:0] S  = 2'd0, P = 2'd1, E = 2'd2;
    localparam logic [6:0] M_START = 7'b0000011;  // bg + start screen
    localparam logic [6:0] M_PLAY  = 7'b0111101;  // bg, blocks, time bar, character, points
    localparam logic [6:0] M_END   = 7'b1100101;  // bg, blocks, points, end screen

    localparam logic [5:0] I_NONE = 6'b000000, I_TICK = 6'b100000, I_BTN = 6'b010000,
                           I_JL = 6'b001000, I_JR = 6'b000100, I_OK = 6'b000010,
                           I_MISS = 6'b000001;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    sb_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t cur_obs();
        obs_t o;
        o.st = state_out; o.lay = layer_en; o.jl = jump_left_out; o.jr = jump_right_out;
        o.tb = time_bar_start; o.pts = points; o.best = best_points; o.go = game_over;
        return o;
    endfunction

    function automatic obs_t mk(logic [1:0] st, logic [2:0] p, logic [2:0] b,
                                logic jl, logic jr, logic tb);
        obs_t o;
        o.st   = st;
        o.lay  = (st == P) ? M_PLAY : (st == E) ? M_END : M_START;
        o.jl   = jl; o.jr = jr; o.tb = tb;
        o.pts  = p; o.best = b;
        o.go   = (st == E);
        return o;
    endfunction

    // Scoreboard: compare the head entry once the cycle it was due in arrives.
    always @(negedge clk) begin
        sb_t  it;
        obs_t got;
        if (q.size() > 0 && q[0].due == cyc) begin
            it  = q.pop_front();
            got = cur_obs();
            checks++;
            if (got !== it.e) begin
                errors++;
                $display("FAIL %s: got st=%0d lay=%b jl=%b jr=%b tb=%b pts=%0d best=%0d go=%b, want st=%0d lay=%b jl=%b jr=%b tb=%b pts=%0d best=%0d go=%b",
                         it.nm, got.st, got.lay, got.jl, got.jr, got.tb, got.pts, got.best, got.go,
                         it.e.st, it.e.lay, it.e.jl, it.e.jr, it.e.tb, it.e.pts, it.e.best, it.e.go);
            end
        end
    end

    task automatic step(input logic [5:0] in, input obs_t e, input string nm);
        sb_t it;
        it.due = cyc + 1; it.e = e; it.nm = nm;
        q.push_back(it);
        {one_ms_tick, btn_start, jump_left, jump_right, landed_ok, landed_miss} = in;
        @(posedge clk); #1;
        {one_ms_tick, btn_start, jump_left, jump_right, landed_ok, landed_miss} = I_NONE;
    endtask

    task automatic test_reset();
        obs_t got;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        got = cur_obs();
        checks++;
        if (got !== mk(S, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset: got %h want %h", got, mk(S, 0, 0, 0, 0, 0));
        end
        rst = 1'b0;
        step(I_NONE, mk(S, 0, 0, 0, 0, 0), "reset_idle");
    endtask

    task automatic test_start();
        step(I_BTN,  mk(P, 0, 0, 0, 0, 1), "start_btn");
        step(I_NONE, mk(P, 0, 0, 0, 0, 0), "start_tb_one_cycle");
    endtask

    task automatic test_miss_with_ok();
        step(I_OK,          mk(P, 1, 0, 0, 0, 0), "miss_ok1");
        step(I_OK,          mk(P, 2, 0, 0, 0, 0), "miss_ok2");
        step(I_OK | I_MISS, mk(E, 2, 2, 0, 0, 0), "miss_ok_not_counted");
    endtask

    task automatic test_lockout(input logic [2:0] p, input logic [2:0] b);
        step(I_TICK, mk(E, p, b, 0, 0, 0), "lock_tick1");
        step(I_BTN,  mk(E, p, b, 0, 0, 0), "lock_btn_ignored");
        step(I_TICK, mk(E, p, b, 0, 0, 0), "lock_tick2");
        step(I_TICK, mk(E, p, b, 0, 0, 0), "lock_tick3");
        step(I_JL,   mk(E, p, b, 0, 0, 0), "lock_jump_ignored");
        step(I_BTN,  mk(S, p, b, 0, 0, 0), "lock_btn_restart");
    endtask

    task automatic test_jumps();
        step(I_JL,        mk(P, 0, 2, 0, 0, 1), "jump_starts_no_fwd");
        step(I_JL,        mk(P, 0, 2, 1, 0, 1), "jump_left_fwd");
        step(I_NONE,      mk(P, 0, 2, 0, 0, 0), "jump_left_one_cycle");
        step(I_BTN,       mk(P, 0, 2, 0, 0, 0), "play_btn_ignored");
        for (int i = 1; i <= 3; i++)
            step(I_OK, mk(P, 3'(i), 2, 0, 0, 0), "jump_ok_count");
        step(I_JL | I_JR, mk(P, 3, 2, 0, 0, 0), "jump_both_dropped");
        step(I_JR,        mk(P, 3, 2, 0, 1, 1), "jump_right_fwd");
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= 4; i++)
            step(I_TICK, mk(P, 3, 2, 0, 0, 0), "timeout_count");
        step(I_TICK | I_JL | I_OK, mk(E, 3, 3, 0, 0, 0), "timeout_expire");
    endtask

    task automatic test_saturate();
        step(I_BTN, mk(P, 0, 3, 0, 0, 1), "sat_start");
        for (int i = 1; i <= 9; i++)
            step(I_OK, mk(P, 3'((i > 7) ? 7 : i), 3, 0, 0, 0), "sat_ok");
        step(I_MISS, mk(E, 7, 7, 0, 0, 0), "sat_end");
    endtask

    task automatic test_rst_mid_play();
        obs_t got;
        step(I_BTN, mk(P, 0, 7, 0, 0, 1), "rst_mid_start");
        step(I_OK,  mk(P, 1, 7, 0, 0, 0), "rst_mid_ok");
        rst = 1'b1;
        @(posedge clk); #1;
        got = cur_obs();
        checks++;
        if (got !== mk(S, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL rst_mid_play: got %h want %h", got, mk(S, 0, 0, 0, 0, 0));
        end
        rst = 1'b0;
        step(I_JR, mk(P, 0, 0, 0, 0, 1), "rst_mid_restart");
    endtask

    initial begin
        test_reset();
        test_start();
        test_miss_with_ok();
        test_lockout(2, 2);
        test_jumps();
        test_timeout();
        test_lockout(3, 3);
        test_saturate();
        test_lockout(7, 7);
        test_rst_mid_play();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
